// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: forwarding resolution,
// load-use hazard stall and the ID/EX valid/ready register.
module id_operand_stage #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               re1,
  input  logic               re2,
  input  logic [AW-1:0]      reg_addr1,
  input  logic [AW-1:0]      reg_addr2,
  input  logic [XLEN-1:0]    reg_data1,
  input  logic [XLEN-1:0]    reg_data2,
  input  logic [XLEN-1:0]    imm,
  input  logic [AW-1:0]      waddr,
  input  logic               we,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]    fwd_is_load,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_opv1,
  output logic [XLEN-1:0]    ex_opv2,
  output logic [AW-1:0]      ex_waddr,
  output logic               ex_we,
  output logic [31:0]        stall_cycles
);

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    logic            hz;
    logic [XLEN-1:0] val;
  } opnd_t;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ex_valid_q;
  logic [XLEN-1:0] opv1_q, opv2_q;
  logic [AW-1:0]   waddr_q;
  logic            we_q;
  logic [31:0]     stall_q;

  opnd_t src1, src2;
  logic  hazard;
  logic  load;
  logic  accept;
  logic  stall_inc;

  // First matching port wins; a load there blocks lower ports.
  function automatic opnd_t resolve(
    input logic               re,
    input logic [AW-1:0]      addr,
    input logic [XLEN-1:0]    rdata,
    input logic [XLEN-1:0]    dflt,
    input logic [NFWD-1:0]    f_we,
    input logic [NFWD*AW-1:0] f_addr,
    input logic [NFWD*XLEN-1:0] f_data,
    input logic [NFWD-1:0]    f_ld
  );
    opnd_t r;
    logic  hit;
    r.hz  = 1'b0;
    r.val = dflt;
    hit   = 1'b0;
    if (re) begin
      r.val = '0;
      if (addr != '0) begin
        r.val = rdata;
        for (int i = 0; i < NFWD; i++) begin
          if (!hit && f_we[i] &&
              f_addr[i*AW +: AW] == addr) begin
            hit = 1'b1;
            if (f_ld[i]) r.hz = 1'b1;
            else r.val = f_data[i*XLEN +: XLEN];
          end
        end
      end
    end
    return r;
  endfunction

  // Operand resolution and handshake qualifiers.
  always_comb begin
    src1 = resolve(re1, reg_addr1, reg_data1, '0,
                   fwd_we, fwd_waddr, fwd_wdata,
                   fwd_is_load);
    src2 = resolve(re2, reg_addr2, reg_data2, imm,
                   fwd_we, fwd_waddr, fwd_wdata,
                   fwd_is_load);
    hazard   = src1.hz | src2.hz;
    load     = !ex_valid_q || ex_ready;
    in_ready = flush ||
               (state_q == RUN && !hazard && load);
    accept   = in_valid && in_ready && !flush;
    stall_inc = !flush &&
                (state_q == STALL ||
                 (in_valid && hazard));
  end

  // Hazard FSM next state; frozen while EX back-pressures.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (load) begin
      unique case (state_q)
        RUN: begin
          if (in_valid && hazard) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end
        STALL: begin
          if (cnt_q == '0) state_d = RUN;
          else cnt_d = cnt_q - 4'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state and bubble counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ID/EX register: capture, bubble or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      opv1_q     <= '0;
      opv2_q     <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      opv1_q     <= src1.val;
      opv2_q     <= src2.val;
      waddr_q    <= waddr;
      we_q       <= we;
    end else if (load) begin
      ex_valid_q <= 1'b0;
    end
  end

  // Saturating hazard-stall cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_inc && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_opv1      = opv1_q;
  assign ex_opv2      = opv2_q;
  assign ex_waddr     = waddr_q;
  assign ex_we        = we_q;
  assign stall_cycles = stall_q;

endmodule
